// File: rtl/if_prefetch_if.sv
// Fetch-stage bus bundle: stb/ack instruction-memory port, decode-side valid/ready stream and redirect.
// master = fetch stage, slave = the memory/decode/branch environment around it.
interface if_prefetch_if #(
  parameter int XLEN = 32
);
  logic            o_imem_stb;
  logic [XLEN-1:0] o_iaddr;
  logic [XLEN-1:0] i_inst;
  logic            i_imem_ack;
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_instr;

  modport master (
    output o_imem_stb, o_iaddr, o_valid, o_pc, o_instr,
    input  i_inst, i_imem_ack, i_redirect, i_redirect_pc, i_ready
  );

  modport slave (
    input  o_imem_stb, o_iaddr, o_valid, o_pc, o_instr,
    output i_inst, i_imem_ack, i_redirect, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/if_prefetch.sv
// Instruction fetch stage: one-outstanding stb/ack fetcher feeding a DEPTH-entry {pc, instr}
// prefetch FIFO, with a redirect that flushes all fetched-but-unconsumed work.
module if_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  if_prefetch_if.master            bus,
  output logic [1:0]               o_dbg_state,
  output logic [$clog2(DEPTH):0]   o_dbg_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_d [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] instr_mem_d [DEPTH];

  logic has_space;
  logic ack;
  logic push;
  logic pop;
  logic redir;

  // Decode stream: an entry transfers on every cycle with o_valid & i_ready both high;
  // o_valid never depends on i_ready, and the head holds until that transfer happens.
  assign redir     = bus.i_redirect;
  assign has_space = (count_q < CW'(DEPTH));
  assign ack       = bus.i_imem_ack & (state_q != S_IDLE);
  assign push      = (state_q == S_REQ) & ack & ~redir;
  assign pop       = bus.o_valid & bus.i_ready;

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (!redir && has_space) begin
          state_d = S_REQ;
          addr_d  = fpc_q;
        end
      end
      S_REQ: begin
        if (ack) begin
          state_d = S_IDLE;
          if (!redir) fpc_d = fpc_q + XLEN'(4);
        end else if (redir) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // The bus request cannot be withdrawn, so wait out its ack and discard it.
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (redir) fpc_d = bus.i_redirect_pc & ~XLEN'(1);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A redirect flushes everything, including a push and a pop in this same cycle.
    if (redir) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (push) begin
      pc_mem_d[wr_ptr_q]    = addr_q;
      instr_mem_d[wr_ptr_q] = bus.i_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      fpc_q    <= PC_RESET;
      addr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is qualified by count, so its contents need no reset.
  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

  assign bus.o_imem_stb = (state_q != S_IDLE);
  assign bus.o_iaddr    = bus.o_imem_stb ? addr_q : '0;
  assign bus.o_valid    = (count_q != '0);
  assign bus.o_pc       = bus.o_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign bus.o_instr    = bus.o_valid ? instr_mem_q[rd_ptr_q] : NOP;

  assign o_dbg_state = state_q;
  assign o_dbg_count = count_q;
endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: stb/ack memory responder, request and decode-stream
// monitors popping hand-computed expected queues, and a final error summary.
module tb_if_prefetch;
  localparam int          XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  logic [2:0] dbg_count;

  if_prefetch_if #(.XLEN(XLEN)) bus ();

  if_prefetch #(.XLEN(XLEN), .DEPTH(4), .PC_RESET(32'h0), .NOP(NOP)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_count (dbg_count)
  );

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int          len_q[$];
  int          pop_cnt;
  int          req_cnt;

  bit          resp_en;
  int          lat;
  int          wait_cnt;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic resp_on(input int l);
    lat      = l;
    wait_cnt = 0;
    resp_en  = 1'b1;
  endtask

  task automatic resp_off();
    resp_en        = 1'b0;
    bus.i_imem_ack = 1'b0;
  endtask

  task automatic exp_data(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  task automatic start_test();
    pop_cnt = 0;
    req_cnt = 0;
    len_q.delete();
  endtask

  task automatic end_test(input string name);
    chk({name, "_data_drained"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_req_drained"}, 64'(exp_addr_q.size()), 64'd0);
    exp_q.delete();
    exp_addr_q.delete();
    resp_off();
    bus.i_redirect = 1'b0;
    bus.i_ready    = 1'b0;
    rst_n          = 1'b0;
    tick(2);
  endtask

  // Zero-or-more wait cycles, then a one-cycle ack with instr = {C0DE, addr[15:0]}.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en) begin
        if (bus.o_imem_stb) begin
          if (wait_cnt == lat) begin
            bus.i_imem_ack = 1'b1;
            bus.i_inst     = {16'hC0DE, bus.o_iaddr[15:0]};
            wait_cnt       = 0;
          end else begin
            bus.i_imem_ack = 1'b0;
            wait_cnt++;
          end
        end else begin
          bus.i_imem_ack = 1'b0;
          wait_cnt       = 0;
        end
      end
    end
  end

  // ---------------- scoreboard monitors ----------------
  initial begin
    logic        stb_prev;
    logic [31:0] held;
    int          stb_len;
    stb_prev = 1'b0;
    held     = '0;
    stb_len  = 0;
    forever begin
      @(negedge clk);
      if (bus.o_imem_stb) begin
        if (!stb_prev) begin
          req_cnt++;
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected: got addr %h expected no request", bus.o_iaddr);
          end else begin
            chk("req_addr", 64'(bus.o_iaddr), 64'(exp_addr_q.pop_front()));
          end
          held    = bus.o_iaddr;
          stb_len = 1;
        end else begin
          chk("req_addr_stable", 64'(bus.o_iaddr), 64'(held));
          stb_len++;
        end
      end else if (stb_prev) begin
        len_q.push_back(stb_len);
      end
      stb_prev = bus.o_imem_stb;
    end
  end

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_valid && bus.i_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got pc %h instr %h expected no entry", bus.o_pc, bus.o_instr);
        end else begin
          e = exp_q.pop_front();
          chk("pop_entry", {bus.o_pc, bus.o_instr}, e);
        end
      end else if (!bus.o_valid) begin
        chk("idle_outputs", {bus.o_pc, bus.o_instr}, {32'h0, NOP});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n             = 1'b0;
    bus.i_inst        = '0;
    bus.i_imem_ack    = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_ready       = 1'b0;
    resp_en           = 1'b0;
    lat               = 0;
    wait_cnt          = 0;
    start_test();
    tick(3);

    chk("rst_stb", 64'(bus.o_imem_stb), 64'd0);
    chk("rst_iaddr", 64'(bus.o_iaddr), 64'd0);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_pc", 64'(bus.o_pc), 64'd0);
    chk("rst_instr", 64'(bus.o_instr), 64'(NOP));
    chk("rst_state", 64'(dbg_state), 64'd0);

    // T1: zero-wait memory, decode always ready
    start_test();
    exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    exp_data(32'h0, 32'hC0DE_0000);
    exp_data(32'h4, 32'hC0DE_0004);
    exp_data(32'h8, 32'hC0DE_0008);
    exp_data(32'hC, 32'hC0DE_000C);
    resp_on(0);
    bus.i_ready = 1'b1;
    rst_n = 1'b1;
    tick(1);
    chk("t1_c1_stb", 64'(bus.o_imem_stb), 64'd1);
    chk("t1_c1_valid", 64'(bus.o_valid), 64'd0);
    tick(1);
    chk("t1_c2_stb", 64'(bus.o_imem_stb), 64'd0);
    chk("t1_c2_valid", 64'(bus.o_valid), 64'd1);
    tick(7);
    resp_off();
    tick(2);
    chk("t1_pops", 64'(pop_cnt), 64'd4);
    chk("t1_hang_addr", 64'(bus.o_iaddr), 64'h10);
    chk("t1_hang_state", 64'(dbg_state), 64'd1);
    end_test("t1");

    // T2: decode stalled, FIFO fills to DEPTH, one pop frees exactly one fetch
    start_test();
    exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    resp_on(0);
    rst_n = 1'b1;
    tick(12);
    chk("t2_full_stb", 64'(bus.o_imem_stb), 64'd0);
    chk("t2_full_count", 64'(dbg_count), 64'd4);
    exp_data(32'h0, 32'hC0DE_0000);
    bus.i_ready = 1'b1;
    tick(1);
    bus.i_ready = 1'b0;
    chk("t2_after_pop_count", 64'(dbg_count), 64'd3);
    chk("t2_after_pop_pc", 64'(bus.o_pc), 64'h4);
    tick(5);
    chk("t2_refill_stb", 64'(bus.o_imem_stb), 64'd0);
    chk("t2_refill_count", 64'(dbg_count), 64'd4);
    chk("t2_req_cnt", 64'(req_cnt), 64'd5);
    end_test("t2");

    // T3: three-cycle ack latency
    start_test();
    exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_data(32'h0, 32'hC0DE_0000);
    exp_data(32'h4, 32'hC0DE_0004);
    exp_data(32'h8, 32'hC0DE_0008);
    resp_on(2);
    bus.i_ready = 1'b1;
    rst_n = 1'b1;
    tick(12);
    resp_off();
    tick(2);
    chk("t3_bursts", 64'(len_q.size()), 64'd3);
    foreach (len_q[i]) chk("t3_stb_len", 64'(len_q[i]), 64'd3);
    chk("t3_pops", 64'(pop_cnt), 64'd3);
    end_test("t3");

    // T4: redirect while a request is pending, its ack lands two cycles later
    start_test();
    exp_addr_q = '{32'h0, 32'h1000, 32'h1004};
    exp_data(32'h1000, 32'hC0DE_1000);
    resp_on(2);
    bus.i_ready = 1'b1;
    rst_n = 1'b1;
    tick(1);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h1001;
    tick(1);
    bus.i_redirect = 1'b0;
    chk("t4_drop_state", 64'(dbg_state), 64'd2);
    chk("t4_drop_stb", 64'(bus.o_imem_stb), 64'd1);
    chk("t4_drop_count", 64'(dbg_count), 64'd0);
    tick(2);
    chk("t4_after_drop_state", 64'(dbg_state), 64'd0);
    chk("t4_after_drop_count", 64'(dbg_count), 64'd0);
    tick(4);
    resp_off();
    tick(2);
    chk("t4_pops", 64'(pop_cnt), 64'd1);
    end_test("t4");

    // T5: redirect coinciding with ack and pop while two entries are buffered
    start_test();
    exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'h2000, 32'h2004, 32'h2008};
    resp_on(0);
    rst_n = 1'b1;
    tick(5);
    chk("t5_pre_count", 64'(dbg_count), 64'd2);
    exp_data(32'h0, 32'hC0DE_0000);
    exp_data(32'h2000, 32'hC0DE_2000);
    exp_data(32'h2004, 32'hC0DE_2004);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h2000;
    bus.i_ready       = 1'b1;
    tick(1);
    bus.i_redirect = 1'b0;
    chk("t5_flush_count", 64'(dbg_count), 64'd0);
    chk("t5_flush_valid", 64'(bus.o_valid), 64'd0);
    tick(1);
    chk("t5_target_addr", 64'(bus.o_iaddr), 64'h2000);
    tick(3);
    resp_off();
    tick(2);
    chk("t5_pops", 64'(pop_cnt), 64'd3);
    end_test("t5");

    // T6: fetch PC wraps from FFFF_FFFC to 0
    start_test();
    exp_addr_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    exp_data(32'hFFFF_FFFC, 32'hC0DE_FFFC);
    exp_data(32'h0, 32'hC0DE_0000);
    resp_on(0);
    bus.i_ready       = 1'b1;
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'hFFFF_FFFD;
    rst_n = 1'b1;
    tick(1);
    bus.i_redirect = 1'b0;
    tick(4);
    resp_off();
    tick(2);
    chk("t6_pops", 64'(pop_cnt), 64'd2);
    end_test("t6");

    // T7: reset during DROP, stale ack during and after reset
    start_test();
    exp_addr_q = '{32'h0, 32'h0, 32'h4};
    exp_data(32'h0, 32'hC0DE_0000);
    bus.i_ready = 1'b1;
    rst_n = 1'b1;
    tick(1);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h3000;
    tick(1);
    bus.i_redirect = 1'b0;
    chk("t7_drop_state", 64'(dbg_state), 64'd2);
    rst_n = 1'b0;
    tick(1);
    chk("t7_rst_stb", 64'(bus.o_imem_stb), 64'd0);
    chk("t7_rst_iaddr", 64'(bus.o_iaddr), 64'd0);
    chk("t7_rst_valid", 64'(bus.o_valid), 64'd0);
    chk("t7_rst_state", 64'(dbg_state), 64'd0);
    bus.i_imem_ack = 1'b1;
    bus.i_inst     = 32'hDEAD_BEEF;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("t7_stale_count", 64'(dbg_count), 64'd0);
    chk("t7_first_addr", 64'(bus.o_iaddr), 64'h0);
    bus.i_imem_ack = 1'b0;
    resp_on(0);
    tick(1);
    resp_off();
    tick(2);
    chk("t7_pops", 64'(pop_cnt), 64'd1);
    end_test("t7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
